rrf_commit_ctrl: RTL and testbench

- Retirement-side counterpart of the RRF entry allocator.
- Tracks per-entry dispatched/finished state for the rename register file, and retires up to 2 entries per cycle in order from the commit pointer.
- Drives com_inst_num_o back to the allocator so committed entries are freed.
- Drives commit ports toward the architectural register file (ARF).

---
 rtl/rrf_commit_pkg.sv | 13 +
 rtl/rrf_commit_status.sv | 63 ++++++
 rtl/rrf_commit_ctrl.sv | 81 ++++++++
 tb/tb_rrf_commit_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rrf_commit_pkg.sv
// rrf_commit_pkg: shared sizes and types for the RRF commit controller.
package rrf_commit_pkg;
  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;
  localparam int ARF_SEL = 5;
  localparam int COM_WIDTH = 2;
  typedef logic [RRF_SEL-1:0] tag_t;
  typedef logic [ARF_SEL-1:0] arf_t;
  typedef struct packed {
    arf_t arf;
    logic we;
  } dst_t;
endpackage

// File: rtl/rrf_commit_status.sv
// rrf_commit_status: per-entry valid/finished store with set, clear and read ports.
module rrf_commit_status
  import rrf_commit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dp_set1,
  input  tag_t dp_tag1,
  input  logic dp_set2,
  input  tag_t dp_tag2,
  input  logic wb_set1,
  input  tag_t wb_tag1,
  input  logic wb_set2,
  input  tag_t wb_tag2,
  input  logic clr1,
  input  tag_t clr_tag1,
  input  logic clr2,
  input  tag_t clr_tag2,
  input  tag_t rd_tag1,
  input  tag_t rd_tag2,
  output logic rd_valid1,
  output logic rd_fin1,
  output logic rd_valid2,
  output logic rd_fin2
);
  logic [RRF_NUM-1:0] valid, fin, valid_n, fin_n;
  assign rd_valid1 = valid[rd_tag1];
  assign rd_fin1   = fin[rd_tag1];
  assign rd_valid2 = valid[rd_tag2];
  assign rd_fin2   = fin[rd_tag2];
  // Writebacks apply first, commit clears override them, dispatch overrides both.
  always_comb begin
    valid_n = valid;
    fin_n = fin;
    if (wb_set1 && valid[wb_tag1]) fin_n[wb_tag1] = 1'b1;
    if (wb_set2 && valid[wb_tag2]) fin_n[wb_tag2] = 1'b1;
    if (clr1) begin
      valid_n[clr_tag1] = 1'b0;
      fin_n[clr_tag1] = 1'b0;
    end
    if (clr2) begin
      valid_n[clr_tag2] = 1'b0;
      fin_n[clr_tag2] = 1'b0;
    end
    if (dp_set1) begin
      valid_n[dp_tag1] = 1'b1;
      fin_n[dp_tag1] = 1'b0;
    end
    if (dp_set2) begin
      valid_n[dp_tag2] = 1'b1;
      fin_n[dp_tag2] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      fin <= '0;
    end else begin
      valid <= valid_n;
      fin <= fin_n;
    end
  end
endmodule

// File: rtl/rrf_commit_ctrl.sv
// rrf_commit_ctrl: in-order retirement of up to two RRF entries per cycle from the commit pointer.
module rrf_commit_ctrl
  import rrf_commit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         dp_num_i,
  input  logic [RRF_SEL-1:0] rrfptr_i,
  input  logic [ARF_SEL-1:0] dp_dstarf1_i,
  input  logic               dp_dstwe1_i,
  input  logic [ARF_SEL-1:0] dp_dstarf2_i,
  input  logic               dp_dstwe2_i,
  input  logic               wb_valid1_i,
  input  logic [RRF_SEL-1:0] wb_tag1_i,
  input  logic               wb_valid2_i,
  input  logic [RRF_SEL-1:0] wb_tag2_i,
  input  logic               commit_stall_i,
  output logic [1:0]         com_inst_num_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic               com_valid1_o,
  output logic [RRF_SEL-1:0] com_rrftag1_o,
  output logic [ARF_SEL-1:0] com_dstarf1_o,
  output logic               com_arfwe1_o,
  output logic               com_valid2_o,
  output logic [RRF_SEL-1:0] com_rrftag2_o,
  output logic [ARF_SEL-1:0] com_dstarf2_o,
  output logic               com_arfwe2_o
);
  tag_t comptr, comptr1, dp_tag2;
  dst_t tab [RRF_NUM];
  logic dp1, dp2, v1, f1, v2, f2, c1, c2;
  assign comptr1 = comptr + tag_t'(1);
  assign dp_tag2 = rrfptr_i + tag_t'(1);
  // An encoding of 3 is illegal and dispatches nothing.
  assign dp1 = (dp_num_i == 2'd1) || (dp_num_i == 2'd2);
  assign dp2 = dp_num_i == 2'd2;
  assign c1 = !commit_stall_i && v1 && f1;
  assign c2 = c1 && v2 && f2;
  assign com_inst_num_o = {c2, c1 && !c2};
  assign comptr_o = comptr;
  assign com_valid1_o = c1;
  assign com_valid2_o = c2;
  assign com_rrftag1_o = comptr;
  assign com_rrftag2_o = comptr1;
  assign com_dstarf1_o = tab[comptr].arf;
  assign com_dstarf2_o = tab[comptr1].arf;
  assign com_arfwe1_o = c1 && tab[comptr].we;
  assign com_arfwe2_o = c2 && tab[comptr1].we;
  rrf_commit_status u_status (
    .clk(clk_i),
    .rst(reset_i),
    .dp_set1(dp1),
    .dp_tag1(rrfptr_i),
    .dp_set2(dp2),
    .dp_tag2(dp_tag2),
    .wb_set1(wb_valid1_i),
    .wb_tag1(wb_tag1_i),
    .wb_set2(wb_valid2_i),
    .wb_tag2(wb_tag2_i),
    .clr1(c1),
    .clr_tag1(comptr),
    .clr2(c2),
    .clr_tag2(comptr1),
    .rd_tag1(comptr),
    .rd_tag2(comptr1),
    .rd_valid1(v1),
    .rd_fin1(f1),
    .rd_valid2(v2),
    .rd_fin2(f2)
  );
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      comptr <= '0;
      for (int i = 0; i < RRF_NUM; i++) tab[i] <= '0;
    end else begin
      comptr <= comptr + tag_t'(com_inst_num_o);
      if (dp1) tab[rrfptr_i] <= '{arf: dp_dstarf1_i, we: dp_dstwe1_i};
      if (dp2) tab[dp_tag2] <= '{arf: dp_dstarf2_i, we: dp_dstwe2_i};
    end
  end
endmodule

// File: tb/tb_rrf_commit_ctrl.sv
// tb_rrf_commit_ctrl: directed and randomized checks against an array-based retirement model.
module tb_rrf_commit_ctrl;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [1:0] dp_num_i;
  logic [5:0] rrfptr_i;
  logic [4:0] dp_dstarf1_i, dp_dstarf2_i;
  logic       dp_dstwe1_i, dp_dstwe2_i;
  logic       wb_valid1_i, wb_valid2_i;
  logic [5:0] wb_tag1_i, wb_tag2_i;
  logic       commit_stall_i;
  logic [1:0] com_inst_num_o;
  logic [5:0] comptr_o, com_rrftag1_o, com_rrftag2_o;
  logic       com_valid1_o, com_valid2_o, com_arfwe1_o, com_arfwe2_o;
  logic [4:0] com_dstarf1_o, com_dstarf2_o;

  always #5 clk_i = ~clk_i;

  rrf_commit_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .dp_num_i(dp_num_i), .rrfptr_i(rrfptr_i),
    .dp_dstarf1_i(dp_dstarf1_i), .dp_dstwe1_i(dp_dstwe1_i),
    .dp_dstarf2_i(dp_dstarf2_i), .dp_dstwe2_i(dp_dstwe2_i),
    .wb_valid1_i(wb_valid1_i), .wb_tag1_i(wb_tag1_i),
    .wb_valid2_i(wb_valid2_i), .wb_tag2_i(wb_tag2_i),
    .commit_stall_i(commit_stall_i), .com_inst_num_o(com_inst_num_o), .comptr_o(comptr_o),
    .com_valid1_o(com_valid1_o), .com_rrftag1_o(com_rrftag1_o),
    .com_dstarf1_o(com_dstarf1_o), .com_arfwe1_o(com_arfwe1_o),
    .com_valid2_o(com_valid2_o), .com_rrftag2_o(com_rrftag2_o),
    .com_dstarf2_o(com_dstarf2_o), .com_arfwe2_o(com_arfwe2_o)
  );

  int checks = 0;
  int failures = 0;
  bit mv [64];
  bit mf [64];
  bit mwe [64];
  int marf [64];
  int cp = 0;
  int ap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dp_num_i = 0; rrfptr_i = 6'(ap);
    dp_dstarf1_i = 0; dp_dstwe1_i = 0; dp_dstarf2_i = 0; dp_dstwe2_i = 0;
    wb_valid1_i = 0; wb_tag1_i = 0; wb_valid2_i = 0; wb_tag2_i = 0;
    commit_stall_i = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0; mf[i] = 0; mwe[i] = 0; marf[i] = 0;
    end
    cp = 0; ap = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_num"}, com_inst_num_o, 0);
    chk({tag, "_comptr"}, comptr_o, 0);
    chk({tag, "_valid1"}, com_valid1_o, 0);
    chk({tag, "_valid2"}, com_valid2_o, 0);
    chk({tag, "_arfwe1"}, com_arfwe1_o, 0);
    chk({tag, "_arfwe2"}, com_arfwe2_o, 0);
    chk({tag, "_rrftag1"}, com_rrftag1_o, 0);
  endtask

  // Compare outputs against the model, clock once, then retire/writeback/dispatch in the model.
  task automatic cycle();
    int n1;
    bit e1, e2;
    int k;
    int p;
    n1 = (cp + 1) % 64;
    e1 = !commit_stall_i && mv[cp] && mf[cp];
    e2 = e1 && mv[n1] && mf[n1];
    #1;
    chk("num", com_inst_num_o, int'(e1) + int'(e2));
    chk("valid1", com_valid1_o, e1);
    chk("valid2", com_valid2_o, e2);
    chk("rrftag1", com_rrftag1_o, cp);
    chk("rrftag2", com_rrftag2_o, n1);
    chk("comptr", comptr_o, cp);
    chk("arfwe1", com_arfwe1_o, e1 && mwe[cp]);
    chk("arfwe2", com_arfwe2_o, e2 && mwe[n1]);
    if (e1) chk("dstarf1", com_dstarf1_o, marf[cp]);
    if (e2) chk("dstarf2", com_dstarf2_o, marf[n1]);
    @(posedge clk_i);
    if (wb_valid1_i && mv[wb_tag1_i] && !(e1 && wb_tag1_i == cp) && !(e2 && wb_tag1_i == n1))
      mf[wb_tag1_i] = 1;
    if (wb_valid2_i && mv[wb_tag2_i] && !(e1 && wb_tag2_i == cp) && !(e2 && wb_tag2_i == n1))
      mf[wb_tag2_i] = 1;
    if (e1) begin mv[cp] = 0; mf[cp] = 0; end
    if (e2) begin mv[n1] = 0; mf[n1] = 0; end
    k = (dp_num_i == 3) ? 0 : int'(dp_num_i);
    p = int'(rrfptr_i);
    if (k >= 1) begin mv[p] = 1; mf[p] = 0; marf[p] = dp_dstarf1_i; mwe[p] = dp_dstwe1_i; end
    if (k == 2) begin
      p = (p + 1) % 64;
      mv[p] = 1; mf[p] = 0; marf[p] = dp_dstarf2_i; mwe[p] = dp_dstwe2_i;
    end
    if (k > 0) ap = (int'(rrfptr_i) + k) % 64;
    cp = (cp + int'(e1) + int'(e2)) % 64;
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    int last;
    int k;
    idle();
    model_reset();
    #2 reset_i = 1;
    #1 check_reset("reset");
    @(negedge clk_i);
    reset_i = 0;

    dp_num_i = 2; rrfptr_i = 0;
    dp_dstarf1_i = 3; dp_dstwe1_i = 1; dp_dstarf2_i = 4; dp_dstwe2_i = 1;
    cycle();
    wb_valid1_i = 1; wb_tag1_i = 0; wb_valid2_i = 1; wb_tag2_i = 1;
    cycle();
    #1;
    chk("pair_num", com_inst_num_o, 2);
    chk("pair_dstarf1", com_dstarf1_o, 3);
    chk("pair_dstarf2", com_dstarf2_o, 4);
    chk("pair_arfwe1", com_arfwe1_o, 1);
    chk("pair_arfwe2", com_arfwe2_o, 1);
    cycle();
    chk("pair_comptr", comptr_o, 2);

    dp_num_i = 2; rrfptr_i = 2;
    dp_dstarf1_i = 5; dp_dstwe1_i = 1; dp_dstarf2_i = 6; dp_dstwe2_i = 1;
    cycle();
    wb_valid1_i = 1; wb_tag1_i = 3;
    cycle();
    #1 chk("block_num", com_inst_num_o, 0);
    wb_valid1_i = 1; wb_tag1_i = 2;
    cycle();
    #1 chk("unblock_num", com_inst_num_o, 2);
    cycle();

    dp_num_i = 2; rrfptr_i = 4;
    dp_dstarf1_i = 7; dp_dstwe1_i = 0; dp_dstarf2_i = 8; dp_dstwe2_i = 1;
    cycle();
    wb_valid1_i = 1; wb_tag1_i = 4;
    cycle();
    #1;
    chk("partial_num", com_inst_num_o, 1);
    chk("partial_valid2", com_valid2_o, 0);
    chk("nowrite_valid1", com_valid1_o, 1);
    chk("nowrite_arfwe1", com_arfwe1_o, 0);
    cycle();
    chk("partial_comptr", comptr_o, 5);
    wb_valid1_i = 1; wb_tag1_i = 5;
    cycle();
    cycle();

    last = -1;
    for (int i = 0; i < 300 && cp != 63; i++) begin
      if (last >= 0) begin wb_valid1_i = 1; wb_tag1_i = 6'(last); end
      last = -1;
      if (ap != 63) begin
        dp_num_i = 1; rrfptr_i = 6'(ap);
        dp_dstarf1_i = 5'($urandom_range(0, 31)); dp_dstwe1_i = 1'($urandom_range(0, 1));
        last = ap;
      end
      cycle();
    end
    chk("reach_63", comptr_o, 63);

    dp_num_i = 2; rrfptr_i = 63;
    dp_dstarf1_i = 9; dp_dstwe1_i = 1; dp_dstarf2_i = 10; dp_dstwe2_i = 1;
    cycle();
    wb_valid1_i = 1; wb_tag1_i = 63; wb_valid2_i = 1; wb_tag2_i = 0;
    cycle();
    commit_stall_i = 1;
    #1 chk("stall_num", com_inst_num_o, 0);
    cycle();
    chk("stall_comptr", comptr_o, 63);
    #1;
    chk("wrap_tag1", com_rrftag1_o, 63);
    chk("wrap_tag2", com_rrftag2_o, 0);
    chk("wrap_num", com_inst_num_o, 2);
    chk("wrap_dstarf2", com_dstarf2_o, 10);
    cycle();
    chk("wrap_comptr", comptr_o, 1);

    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        #2 reset_i = 1;
        #1 check_reset("midreset");
        model_reset();
        @(negedge clk_i);
        reset_i = 0;
        idle();
      end
      k = $urandom_range(0, 3);
      if (k == 1 && mv[ap]) k = 0;
      if (k == 2 && (mv[ap] || mv[(ap + 1) % 64])) k = 0;
      dp_num_i = 2'(k); rrfptr_i = 6'(ap);
      dp_dstarf1_i = 5'($urandom_range(0, 31)); dp_dstwe1_i = 1'($urandom_range(0, 1));
      dp_dstarf2_i = 5'($urandom_range(0, 31)); dp_dstwe2_i = 1'($urandom_range(0, 1));
      wb_valid1_i = ($urandom_range(0, 9) < 7);
      wb_tag1_i = 6'((cp + $urandom_range(0, 5)) % 64);
      wb_valid2_i = ($urandom_range(0, 9) < 6);
      wb_tag2_i = 6'((cp + $urandom_range(0, 5)) % 64);
      commit_stall_i = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
